// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU (port 0)
// and a DMA/debug port (port 1), with a port-1 burst lock and saturating grant counters.
module data_memory_arbiter #(
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             m0_req,
    input  logic             m0_we,
    input  logic [AW-1:0]    m0_addr,
    input  logic [DW-1:0]    m0_wdata,
    output logic             m0_ack,
    output logic [DW-1:0]    m0_rdata,

    input  logic             m1_req,
    input  logic             m1_we,
    input  logic [AW-1:0]    m1_addr,
    input  logic [DW-1:0]    m1_wdata,
    input  logic             m1_lock,
    output logic             m1_ack,
    output logic [DW-1:0]    m1_rdata,

    output logic [AW-1:0]    mem_a,
    output logic             mem_we,
    output logic [DW-1:0]    mem_wd,
    input  logic [DW-1:0]    mem_rd,

    output logic             busy,
    output logic [CNT_W-1:0] m0_grants,
    output logic [CNT_W-1:0] m1_grants
);

    typedef enum logic [0:0] {StIdle, StResp} state_e;

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic             lock_q, lock_d;
    logic             m0_ack_q, m0_ack_d;
    logic             m1_ack_q, m1_ack_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic [CNT_W-1:0] m0_grants_q, m0_grants_d;
    logic [CNT_W-1:0] m1_grants_q, m1_grants_d;

    logic issue;
    logic winner;

    // Ties go to the port that did not win last, unless port 1 holds an active lock.
    always_comb begin
        issue = (state_q == StIdle) && (m0_req || m1_req);
        if (m0_req && m1_req) begin
            winner = (last_q && lock_q) ? 1'b1 : ~last_q;
        end else begin
            winner = m1_req;
        end
    end

    always_comb begin
        mem_a  = '0;
        mem_we = 1'b0;
        mem_wd = '0;
        if (issue) begin
            if (winner) begin
                mem_a  = m1_addr;
                mem_we = m1_we;
                mem_wd = m1_wdata;
            end else begin
                mem_a  = m0_addr;
                mem_we = m0_we;
                mem_wd = m0_wdata;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        lock_d      = lock_q;
        rdata_d     = rdata_q;
        m0_ack_d    = 1'b0;
        m1_ack_d    = 1'b0;
        m0_grants_d = m0_grants_q;
        m1_grants_d = m1_grants_q;
        unique case (state_q)
            StIdle: begin
                if (issue) begin
                    state_d  = StResp;
                    rdata_d  = mem_rd;
                    m0_ack_d = ~winner;
                    m1_ack_d = winner;
                    last_d   = winner;
                    lock_d   = winner & m1_lock;
                    if (winner) begin
                        if (m1_grants_q != CntMax) m1_grants_d = m1_grants_q + CntOne;
                    end else begin
                        if (m0_grants_q != CntMax) m0_grants_d = m0_grants_q + CntOne;
                    end
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            last_q      <= 1'b1;
            lock_q      <= 1'b0;
            rdata_q     <= '0;
            m0_ack_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
            m0_grants_q <= '0;
            m1_grants_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            lock_q      <= lock_d;
            rdata_q     <= rdata_d;
            m0_ack_q    <= m0_ack_d;
            m1_ack_q    <= m1_ack_d;
            m0_grants_q <= m0_grants_d;
            m1_grants_q <= m1_grants_d;
        end
    end

    assign m0_ack    = m0_ack_q;
    assign m1_ack    = m1_ack_q;
    assign m0_rdata  = rdata_q;
    assign m1_rdata  = rdata_q;
    assign busy      = (state_q == StResp);
    assign m0_grants = m0_grants_q;
    assign m1_grants = m1_grants_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: vector table for arbitration/issue, hand sequences for
// contention, lock bursts, mid-RESP reset and counter saturation; rdata via scoreboard.
module tb_data_memory_arbiter;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned CNT_W = 4;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             m0_req = 1'b0, m0_we = 1'b0, m0_ack;
    logic [AW-1:0]    m0_addr = '0;
    logic [DW-1:0]    m0_wdata = '0, m0_rdata;
    logic             m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0, m1_ack;
    logic [AW-1:0]    m1_addr = '0;
    logic [DW-1:0]    m1_wdata = '0, m1_rdata;
    logic [AW-1:0]    mem_a;
    logic             mem_we;
    logic [DW-1:0]    mem_wd, mem_rd;
    logic             busy;
    logic [CNT_W-1:0] m0_grants, m1_grants;

    data_memory_arbiter #(.AW(AW), .DW(DW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .busy(busy), .m0_grants(m0_grants), .m1_grants(m1_grants)
    );

    always #5 clk = ~clk;

    // Behavioural data_memory: combinational read, write on rising edge.
    logic [DW-1:0] mem [0:255];
    assign mem_rd = mem[mem_a[9:2]];
    always @(posedge clk) if (mem_we) mem[mem_a[9:2]] <= mem_wd;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic          is_wr;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb0[$];
    exp_t sb1[$];

    typedef struct {
        logic r0, w0; logic [31:0] a0, d0;
        logic r1, w1; logic [31:0] a1, d1; logic lk;
        logic [31:0] ea; logic ewe; logic [31:0] ewd;
        logic eack0, eack1; logic [31:0] erd; int eg0, eg1;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Scoreboard: every ack pops the oldest expectation pushed for that port.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (m0_ack === 1'b1) begin
            if (sb0.size() == 0) begin
                checks++; errors++;
                $display("FAIL m0_ack_unexpected got 1 want 0");
            end else begin
                e = sb0.pop_front();
                if (!e.is_wr) chk("m0_rdata", m0_rdata, e.data);
            end
        end
        if (m1_ack === 1'b1) begin
            if (sb1.size() == 0) begin
                checks++; errors++;
                $display("FAIL m1_ack_unexpected got 1 want 0");
            end else begin
                e = sb1.pop_front();
                if (!e.is_wr) chk("m1_rdata", m1_rdata, e.data);
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_lock = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= '0;

        //          r0 w0 a0      d0            r1 w1 a1      d1            lk
        //          ea      ewe ewd           ack0 ack1 erd           g0 g1
        vecs[0] = '{H, H, 'h10, 'hDEADBEEF, L, L, 'h40, 'h0, L,
                    'h10, H, 'hDEADBEEF, H, L, 'h0, 1, 0};
        vecs[1] = '{H, L, 'h10, 'h0, L, L, 'h0, 'h0, L,
                    'h10, L, 'h0, H, L, 'hDEADBEEF, 2, 0};
        vecs[2] = '{H, L, 'h10, 'h0, H, H, 'h20, 'hCAFEF00D, L,
                    'h20, H, 'hCAFEF00D, L, H, 'h0, 2, 1};
        vecs[3] = '{H, H, 'h24, 'h12345678, H, L, 'h20, 'h0, L,
                    'h24, H, 'h12345678, H, L, 'h0, 3, 1};
        vecs[4] = '{H, L, 'h24, 'h0, H, L, 'h20, 'h55AA55AA, H,
                    'h20, L, 'h55AA55AA, L, H, 'hCAFEF00D, 3, 2};
        vecs[5] = '{H, L, 'h24, 'h0, H, L, 'h10, 'h0, L,
                    'h10, L, 'h0, L, H, 'hDEADBEEF, 3, 3};
        vecs[6] = '{H, L, 'h24, 'h77, H, L, 'h24, 'h0, L,
                    'h24, L, 'h77, H, L, 'h12345678, 4, 3};
        vecs[7] = '{L, L, 'h4, 'h0, H, L, 'h0, 'h99, L,
                    'h0, L, 'h99, L, H, 'h0, 4, 4};
        vecs[8] = '{L, H, 'h44, 'hFFFF0000, L, H, 'h48, 'h1, H,
                    'h0, L, 'h0, L, L, 'h0, 4, 4};

        do_reset();
        chk("rst_m0_ack", 32'(m0_ack), 0);
        chk("rst_m1_ack", 32'(m1_ack), 0);
        chk("rst_m0_rdata", m0_rdata, 0);
        chk("rst_m1_rdata", m1_rdata, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_m0_grants", 32'(m0_grants), 0);
        chk("rst_m1_grants", 32'(m1_grants), 0);
        chk("rst_mem_we", 32'(mem_we), 0);

        for (int i = 0; i < 9; i++) begin
            m0_req = vecs[i].r0; m0_we = vecs[i].w0;
            m0_addr = vecs[i].a0; m0_wdata = vecs[i].d0;
            m1_req = vecs[i].r1; m1_we = vecs[i].w1;
            m1_addr = vecs[i].a1; m1_wdata = vecs[i].d1; m1_lock = vecs[i].lk;
            #1;
            chk($sformatf("v%0d_mem_a", i), mem_a, vecs[i].ea);
            chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].ewe));
            chk($sformatf("v%0d_mem_wd", i), mem_wd, vecs[i].ewd);
            if (vecs[i].eack0) sb0.push_back(exp_t'{vecs[i].ewe, vecs[i].erd});
            if (vecs[i].eack1) sb1.push_back(exp_t'{vecs[i].ewe, vecs[i].erd});
            @(posedge clk); #1;
            chk($sformatf("v%0d_m0_ack", i), 32'(m0_ack), 32'(vecs[i].eack0));
            chk($sformatf("v%0d_m1_ack", i), 32'(m1_ack), 32'(vecs[i].eack1));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].eack0 | vecs[i].eack1));
            chk($sformatf("v%0d_m0_grants", i), 32'(m0_grants), 32'(vecs[i].eg0));
            chk($sformatf("v%0d_m1_grants", i), 32'(m1_grants), 32'(vecs[i].eg1));
            m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("v%0d_acks_clear", i), 32'({m0_ack, m1_ack}), 0);
        end

        // Simultaneous reads after reset: port 0 first, port 1 two cycles later.
        do_reset();
        m0_req = 1'b1; m0_addr = 'h0; m1_req = 1'b1; m1_addr = 'h0;
        sb0.push_back(exp_t'{1'b0, 32'h0});
        sb1.push_back(exp_t'{1'b0, 32'h0});
        @(posedge clk); #1;
        chk("tie_e1_m0_ack", 32'(m0_ack), 1);
        chk("tie_e1_m1_ack", 32'(m1_ack), 0);
        chk("tie_e1_busy", 32'(busy), 1);
        m0_req = 1'b0;
        @(posedge clk); #1;
        chk("tie_e2_busy", 32'(busy), 0);
        chk("tie_e2_acks", 32'({m0_ack, m1_ack}), 0);
        @(posedge clk); #1;
        chk("tie_e3_m1_ack", 32'(m1_ack), 1);
        chk("tie_e3_m0_ack", 32'(m0_ack), 0);
        chk("tie_e3_busy", 32'(busy), 1);
        m1_req = 1'b0;
        @(posedge clk); #1;

        // Continuous contention for 20 cycles alternates grants.
        do_reset();
        m0_req = 1'b1; m0_addr = 'h10; m1_req = 1'b1; m1_addr = 'h20;
        for (int k = 0; k < 5; k++) begin
            sb0.push_back(exp_t'{1'b0, 32'hDEADBEEF});
            sb1.push_back(exp_t'{1'b0, 32'hCAFEF00D});
        end
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (c % 2 == 0) begin
                chk($sformatf("rr_c%0d_m0_ack", c), 32'(m0_ack), 32'(((c / 2) % 2) == 0));
                chk($sformatf("rr_c%0d_m1_ack", c), 32'(m1_ack), 32'(((c / 2) % 2) == 1));
            end else begin
                chk($sformatf("rr_c%0d_acks", c), 32'({m0_ack, m1_ack}), 0);
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        chk("rr_m0_grants", 32'(m0_grants), 5);
        chk("rr_m1_grants", 32'(m1_grants), 5);

        // Locked port-1 burst write while port 0 waits.
        do_reset();
        m1_lock = 1'b1; m1_req = 1'b1; m1_we = 1'b1;
        m0_addr = 'h10C; m0_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m1_addr = 32'h100 + 32'(4 * k);
            m1_wdata = 32'hA5000000 + 32'(k);
            sb1.push_back(exp_t'{1'b1, 32'h0});
            @(posedge clk); #1;
            chk($sformatf("lock_k%0d_m1_ack", k), 32'(m1_ack), 1);
            chk($sformatf("lock_k%0d_m0_ack", k), 32'(m0_ack), 0);
            if (k == 0) begin
                m0_req = 1'b1;
                sb0.push_back(exp_t'{1'b0, 32'hA5000003});
            end
            if (k == 3) begin
                m1_req = 1'b0; m1_lock = 1'b0; m1_we = 1'b0;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        chk("lock_m0_ack_after", 32'(m0_ack), 1);
        chk("lock_m1_grants", 32'(m1_grants), 4);
        chk("lock_m0_grants", 32'(m0_grants), 1);
        m0_req = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("lock_mem%0d", k), mem[64 + k], 32'hA5000000 + 32'(k));
        end

        // Reset asserted during the RESP of a read.
        m0_req = 1'b1; m0_addr = 'h10; m0_we = 1'b0;
        sb0.push_back(exp_t'{1'b0, 32'hDEADBEEF});
        @(posedge clk); #1;
        chk("mrst_m0_ack_pre", 32'(m0_ack), 1);
        #2;
        rst_n = 1'b0; m0_req = 1'b0;
        #1;
        chk("mrst_m0_ack", 32'(m0_ack), 0);
        chk("mrst_m0_rdata", m0_rdata, 0);
        chk("mrst_m1_rdata", m1_rdata, 0);
        chk("mrst_m0_grants", 32'(m0_grants), 0);
        chk("mrst_busy", 32'(busy), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m0_req = 1'b1; m0_addr = 'h0; m1_req = 1'b1; m1_addr = 'h0; m1_we = 1'b0;
        sb0.push_back(exp_t'{1'b0, 32'h0});
        sb1.push_back(exp_t'{1'b0, 32'h0});
        @(posedge clk); #1;
        chk("mrst_tie_m0_ack", 32'(m0_ack), 1);
        chk("mrst_tie_m1_ack", 32'(m1_ack), 0);
        m0_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mrst_tie_m1_ack_late", 32'(m1_ack), 1);
        m1_req = 1'b0;
        @(posedge clk); #1;

        // 20 port-0 accesses saturate a 4-bit counter at 15.
        do_reset();
        m0_req = 1'b1; m0_addr = 'h10;
        for (int k = 0; k < 20; k++) sb0.push_back(exp_t'{1'b0, 32'hDEADBEEF});
        repeat (40) @(posedge clk);
        #1;
        m0_req = 1'b0;
        chk("sat_m0_grants", 32'(m0_grants), 15);
        chk("sat_m1_grants", 32'(m1_grants), 0);

        @(posedge clk); #3;
        chk("sb0_drained", 32'(sb0.size()), 0);
        chk("sb1_drained", 32'(sb1.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-port arbiter that shares the single-port `data_memory` between the CPU load/store path (port 0) and a DMA/debug port (port 1), which loads or dumps memory while the core runs. It sits between the requesters and the `data_memory` `a`/`we`/`wd`/`rd` pins.
- Round-robin arbitration, with an optional lock for port-1 bursts.
- Req/ack handshake with registered read data.
- Saturating per-port grant counters for bench statistics.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `CNT_W`, 16, grant counter width
- `clk` in 1: single clock; memory writes commit on its rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `m0_req` in 1: port 0 (CPU) request; held until `m0_ack`
- `m0_we` in 1: port 0 write enable; stable while `m0_req`
- `m0_addr` in AW: port 0 byte address
- `m0_wdata` in DW: port 0 write data
- `m0_ack` out 1: one-cycle completion pulse
- `m0_rdata` out DW: read data, valid while `m0_ack`
- `m1_req`, `m1_we`, `m1_addr`, `m1_wdata`, `m1_ack`, `m1_rdata`: same as port 0, for port 1 (DMA/debug)
- `m1_lock` in 1: port 1 keeps priority while high
- `mem_a` out AW: to `data_memory.a`
- `mem_we` out 1: to `data_memory.we`
- `mem_wd` out DW: to `data_memory.wd`
- `mem_rd` in DW: from `data_memory.rd` (combinational read)
- `busy` out 1: high in state RESP
- `m0_grants` out CNT_W: saturating grant count for port 0
- `m1_grants` out CNT_W: saturating grant count for port 1

## Operation
- State machine with two states, IDLE and RESP.
  - IDLE → RESP when any request is high.
  - RESP → IDLE always.
- Winner selection happens in IDLE only.
  - Only one request high: that port wins.
  - Both high: the port other than `last` wins.
  - Override: if `last`=1, `lock_q`=1 and `m1_req`=1, port 1 wins. `lock_q` is `m1_lock` sampled at port 1's previous grant.
- Issue, in IDLE with a winner (combinational):
  - `mem_a`, `mem_wd` and `mem_we` are driven from the winner's `addr`, `wdata` and `we`.
  - With no winner, or in RESP: `mem_a`=0, `mem_wd`=0, `mem_we`=0.
- At the issuing clock edge:
  - `rdata_q` ← `mem_rd`. This is captured for writes too; the value is then don't-care.
  - The winner's `ack` ← 1 and the other port's `ack` ← 0.
  - `last` ← winner.
  - `lock_q` ← `m1_lock` if the winner is 1, else 0.
  - The winner's grant counter increments, saturating at 2^CNT_W−1.
- In RESP:
  - The winner's `ack` is high and both `rdata` outputs show `rdata_q`.
  - No memory access is issued. The bubble lets the requester drop or change `req`.
  - At the RESP edge both acks clear.
- Requester rules:
  - `req`, `we`, `addr` and `wdata` stay stable from assertion until the `ack` cycle.
  - A request still high in the `ack` cycle is treated as a new request at the next IDLE.
- `m1_lock` can starve port 0. This is intended for the burst dump; the bench must bound lock duration.

## Timing
- Reset (async assert, sync to `clk` on release):
  - state=IDLE, `last`=1 (port 0 wins the first tie), `lock_q`=0.
  - `m0_ack`=`m1_ack`=0, `rdata_q`=0 (both `rdata` outputs 0), `busy`=0.
  - Both counters 0; `mem_we`=0, `mem_a`=0, `mem_wd`=0.
- Latency:
  - A request seen in IDLE at cycle N gets `ack` and `rdata` in cycle N+1.
  - A write is committed at the end of cycle N.
- Throughput is one access per 2 cycles.
- A contending port waits at most 2 cycles, excluding lock.
- A request that rises during RESP is not issued until the following IDLE.
- Reset asserted mid-RESP:
  - The pending `ack` is dropped.
  - A write already committed in the issuing cycle stays committed.
- Counter saturation: at 2^CNT_W−1 the counter holds its value; there is no wrap.

## Test plan
- Single write then read, port 0: write `addr` 0x10, `wdata` 0xDEADBEEF → `m0_ack` in cycle N+1. The read issued in the next IDLE → `m0_rdata`=0xDEADBEEF; `m0_grants`=2.
- Simultaneous requests after reset: both read 0x0 → port 0 is acked first and port 1 two cycles later; `busy` toggles 1,0,1.
- Continuous contention for 20 cycles → grants alternate 0,1,0,1…; `m0_grants`=`m1_grants`=5.
- Lock burst: `m1_lock`=1 with port 1 writing 0x100..0x10C while `m0_req` is high → four port-1 grants, then port 0 is served after `m1_lock` drops. Dumped memory holds the four words.
- Reset mid-operation: assert `rst_n`=0 during the RESP of a read → ack is 0, `rdata` is 0 and counters are 0 immediately. After release, the first tie goes to port 0.
- Saturation with CNT_W=4: 20 port-0 accesses → `m0_grants`=15.
